// File: rtl/fog_job_arbiter.sv
// Round-robin arbiter that shares one FoG core among NREQ requesters.
// It latches the granted job's operands, sequences the core's reset and enable, and captures the result or a watchdog error.
module fog_job_arbiter #(
    parameter int NREQ        = 2,
    parameter int CWIDTH      = 320,
    parameter int XWORDS32    = 9,
    parameter int IWIDTH      = 128,
    parameter int DS_WIDTH    = 4,
    parameter int RWIDTH      = 32,
    parameter int ROUND_COUNT = 10,
    parameter int TIMEOUT     = 1024
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ-1:0]                       req_fog,
    input  logic [NREQ*CWIDTH-1:0]                req_c,
    input  logic [NREQ*XWORDS32*32-1:0]           req_x,
    input  logic [NREQ*IWIDTH-1:0]                req_i,
    input  logic [NREQ*DS_WIDTH-1:0]              req_ds,
    input  logic [NREQ*ROUND_COUNT-1:0]           req_rounds,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic                                  rsp_err,
    output logic [CWIDTH-1:0]                     rsp_c,
    output logic [XWORDS32*32-1:0]                rsp_x,
    output logic [RWIDTH-1:0]                     rsp_r,
    output logic                                  core_reset,
    output logic                                  core_en,
    output logic                                  core_fog,
    output logic [CWIDTH-1:0]                     core_c,
    output logic [XWORDS32*32-1:0]                core_x,
    output logic [IWIDTH-1:0]                     core_i,
    output logic [DS_WIDTH-1:0]                   core_ds,
    output logic [ROUND_COUNT-1:0]                core_rounds,
    input  logic [CWIDTH-1:0]                     core_cout,
    input  logic [XWORDS32*32-1:0]                core_xout,
    input  logic [RWIDTH-1:0]                     core_rout,
    input  logic                                  core_done
);

    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int XWIDTH = XWORDS32 * 32;
    localparam int CNTW   = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;

    logic                   job_fog_q, job_fog_d;
    logic [CWIDTH-1:0]      job_c_q, job_c_d;
    logic [XWIDTH-1:0]      job_x_q, job_x_d;
    logic [IWIDTH-1:0]      job_i_q, job_i_d;
    logic [DS_WIDTH-1:0]    job_ds_q, job_ds_d;
    logic [ROUND_COUNT-1:0] job_rounds_q, job_rounds_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [IDW-1:0]         rsp_id_q, rsp_id_d;
    logic [CWIDTH-1:0]      rsp_c_q, rsp_c_d;
    logic [XWIDTH-1:0]      rsp_x_q, rsp_x_d;
    logic [RWIDTH-1:0]      rsp_r_q, rsp_r_d;

    // Per-requester views of the packed operand buses
    logic [CWIDTH-1:0]      c_arr      [NREQ];
    logic [XWIDTH-1:0]      x_arr      [NREQ];
    logic [IWIDTH-1:0]      i_arr      [NREQ];
    logic [DS_WIDTH-1:0]    ds_arr     [NREQ];
    logic [ROUND_COUNT-1:0] rounds_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign c_arr[gi]      = req_c[gi*CWIDTH +: CWIDTH];
            assign x_arr[gi]      = req_x[gi*XWIDTH +: XWIDTH];
            assign i_arr[gi]      = req_i[gi*IWIDTH +: IWIDTH];
            assign ds_arr[gi]     = req_ds[gi*DS_WIDTH +: DS_WIDTH];
            assign rounds_arr[gi] = req_rounds[gi*ROUND_COUNT +: ROUND_COUNT];
        end
    endgenerate

    // Distance of requester k from the round-robin pointer, wrapping mod NREQ
    function automatic int rr_dist(input int k, input int ptr);
        return (k >= ptr) ? (k - ptr) : (k + NREQ - ptr);
    endfunction

    logic                   grant_found;
    logic [NREQ-1:0]        grant_oh;
    logic [IDW-1:0]         grant_k;
    logic [IDW-1:0]         grant_next;
    int                     best_dist;
    logic                   sel_fog;
    logic [CWIDTH-1:0]      sel_c;
    logic [XWIDTH-1:0]      sel_x;
    logic [IWIDTH-1:0]      sel_i;
    logic [DS_WIDTH-1:0]    sel_ds;
    logic [ROUND_COUNT-1:0] sel_rounds;

    always_comb begin
        grant_found = 1'b0;
        grant_oh    = '0;
        grant_k     = '0;
        grant_next  = '0;
        best_dist   = NREQ;
        sel_fog     = 1'b0;
        sel_c       = '0;
        sel_x       = '0;
        sel_i       = '0;
        sel_ds      = '0;
        sel_rounds  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && (rr_dist(k, int'(rr_ptr_q)) < best_dist)) begin
                best_dist   = rr_dist(k, int'(rr_ptr_q));
                grant_found = 1'b1;
                grant_oh    = '0;
                grant_oh[k] = 1'b1;
                grant_k     = IDW'(k);
                grant_next  = IDW'((k + 1) % NREQ);
                sel_fog     = req_fog[k];
                sel_c       = c_arr[k];
                sel_x       = x_arr[k];
                sel_i       = i_arr[k];
                sel_ds      = ds_arr[k];
                sel_rounds  = rounds_arr[k];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE) ? grant_oh : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        job_fog_d    = job_fog_q;
        job_c_d      = job_c_q;
        job_x_d      = job_x_q;
        job_i_d      = job_i_q;
        job_ds_d     = job_ds_q;
        job_rounds_d = job_rounds_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_id_d     = rsp_id_q;
        rsp_c_d      = rsp_c_q;
        rsp_x_d      = rsp_x_q;
        rsp_r_d      = rsp_r_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    job_fog_d    = sel_fog;
                    job_c_d      = sel_c;
                    job_x_d      = sel_x;
                    job_i_d      = sel_i;
                    job_ds_d     = sel_ds;
                    job_rounds_d = sel_rounds;
                    rsp_id_d     = grant_k;
                    rr_ptr_d     = grant_next;
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving on the last watchdog cycle still counts as success
                if (core_done) begin
                    rsp_c_d     = core_cout;
                    rsp_x_d     = core_xout;
                    rsp_r_d     = core_rout;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    rsp_c_d     = '0;
                    rsp_x_d     = '0;
                    rsp_r_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            job_fog_q    <= 1'b0;
            job_c_q      <= '0;
            job_x_q      <= '0;
            job_i_q      <= '0;
            job_ds_q     <= '0;
            job_rounds_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= '0;
            rsp_c_q      <= '0;
            rsp_x_q      <= '0;
            rsp_r_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            job_fog_q    <= job_fog_d;
            job_c_q      <= job_c_d;
            job_x_q      <= job_x_d;
            job_i_q      <= job_i_d;
            job_ds_q     <= job_ds_d;
            job_rounds_q <= job_rounds_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
            rsp_c_q      <= rsp_c_d;
            rsp_x_q      <= rsp_x_d;
            rsp_r_q      <= rsp_r_d;
        end
    end

    // The core runs only in BUSY and is held in reset everywhere else
    assign core_reset  = (state_q != ST_BUSY);
    assign core_en     = (state_q == ST_BUSY);
    assign core_fog    = job_fog_q;
    assign core_c      = job_c_q;
    assign core_x      = job_x_q;
    assign core_i      = job_i_q;
    assign core_ds     = job_ds_q;
    assign core_rounds = job_rounds_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_r     = rsp_r_q;

endmodule

// File: tb/tb_fog_job_arbiter.sv
// Bench for fog_job_arbiter: a table of jobs plus hand-written sequences, checked against a
// scoreboard of responses predicted from a behavioural FoG stub.
module tb_fog_job_arbiter;

    localparam int NREQ     = 2;
    localparam int CW       = 320;
    localparam int XW32     = 9;
    localparam int XW       = XW32 * 32;
    localparam int IW       = 128;
    localparam int DSW      = 4;
    localparam int RW       = 32;
    localparam int RCW      = 10;
    localparam int TO       = 16;
    localparam int STUB_LAT = 5;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_fog = '0;
    logic [NREQ*CW-1:0]    req_c = '0;
    logic [NREQ*XW-1:0]    req_x = '0;
    logic [NREQ*IW-1:0]    req_i = '0;
    logic [NREQ*DSW-1:0]   req_ds = '0;
    logic [NREQ*RCW-1:0]   req_rounds = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [0:0]            rsp_id;
    logic                  rsp_err;
    logic [CW-1:0]         rsp_c;
    logic [XW-1:0]         rsp_x;
    logic [RW-1:0]         rsp_r;
    logic                  core_reset, core_en, core_fog;
    logic [CW-1:0]         core_c;
    logic [XW-1:0]         core_x;
    logic [IW-1:0]         core_i;
    logic [DSW-1:0]        core_ds;
    logic [RCW-1:0]        core_rounds;
    logic [CW-1:0]         core_cout;
    logic [XW-1:0]         core_xout;
    logic [RW-1:0]         core_rout;
    logic                  core_done;

    fog_job_arbiter #(
        .NREQ(NREQ), .CWIDTH(CW), .XWORDS32(XW32), .IWIDTH(IW), .DS_WIDTH(DSW),
        .RWIDTH(RW), .ROUND_COUNT(RCW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_fog(req_fog),
        .req_c(req_c), .req_x(req_x), .req_i(req_i), .req_ds(req_ds), .req_rounds(req_rounds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_c(rsp_c), .rsp_x(rsp_x), .rsp_r(rsp_r),
        .core_reset(core_reset), .core_en(core_en), .core_fog(core_fog),
        .core_c(core_c), .core_x(core_x), .core_i(core_i), .core_ds(core_ds),
        .core_rounds(core_rounds),
        .core_cout(core_cout), .core_xout(core_xout), .core_rout(core_rout),
        .core_done(core_done)
    );

    always #5 clk = ~clk;

    // Behavioural FoG stub: done on its STUB_LAT-th enabled cycle unless told to hang
    function automatic logic [CW-1:0] f_c(input logic [CW-1:0] c, input logic fog);
        return fog ? ~c : (c + 1);
    endfunction
    function automatic logic [XW-1:0] f_x(input logic [XW-1:0] x, input logic [IW-1:0] i);
        return x ^ XW'({i, i});
    endfunction
    function automatic logic [RW-1:0] f_r(input logic [DSW-1:0] ds, input logic [RCW-1:0] rounds);
        return {ds, 18'd0, rounds};
    endfunction

    int stub_cnt = 0;
    bit stub_hang = 1'b0;
    always @(posedge clk) begin
        if (core_reset) stub_cnt <= 0;
        else if (core_en) stub_cnt <= stub_cnt + 1;
    end
    assign core_done = core_en && !stub_hang && (stub_cnt == STUB_LAT - 1);
    assign core_cout = f_c(core_c, core_fog);
    assign core_xout = f_x(core_x, core_i);
    assign core_rout = f_r(core_ds, core_rounds);

    typedef struct {
        logic [0:0]    id;
        logic          err;
        logic [CW-1:0] c;
        logic [XW-1:0] x;
        logic [RW-1:0] r;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0]  vmask;
        logic [1:0]  fog;
        logic [31:0] c0;
        logic [31:0] c1;
        int          exp_id;
        bit          hang;
        int          hold;
        bit          alter;
    } vec_t;
    vec_t vecs[11];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic load_operands(input vec_t v);
        req_fog = v.fog;
        for (int k = 0; k < NREQ; k++) begin
            req_c[k*CW +: CW] = CW'((k == 0) ? v.c0 : v.c1);
            for (int w = 0; w < XW32; w++) req_x[(k*XW32 + w)*32 +: 32] = $urandom;
            for (int w = 0; w < IW/32; w++) req_i[(k*(IW/32) + w)*32 +: 32] = $urandom;
            req_ds[k*DSW +: DSW]     = DSW'($urandom);
            req_rounds[k*RCW +: RCW] = RCW'($urandom);
        end
    endtask

    // Runs one job from grant to accepted response; entered just after a rising edge
    task automatic run_job(input vec_t v, input int idx);
        int            n, first_en, busy, rst_bad, op_bad, bad, k;
        bit            got;
        exp_t          e, a;
        logic [1:0]    exp_oh;
        logic [CW-1:0] exp_core_c;
        logic          exp_fog;
        stub_hang = v.hang;
        load_operands(v);
        req_valid = v.vmask;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL job%0d grant: got no grant within 20 cycles, required one", idx);
            return;
        end
        exp_oh = '0;
        exp_oh[v.exp_id] = 1'b1;
        chk($sformatf("job%0d grant", idx), CW'(req_ready), CW'(exp_oh));
        k          = v.exp_id;
        exp_core_c = req_c[k*CW +: CW];
        exp_fog    = req_fog[k];
        e.id  = 1'(k);
        e.err = v.hang;
        e.c   = v.hang ? '0 : f_c(exp_core_c, exp_fog);
        e.x   = v.hang ? '0 : f_x(req_x[k*XW +: XW], req_i[k*IW +: IW]);
        e.r   = v.hang ? '0 : f_r(req_ds[k*DSW +: DSW], req_rounds[k*RCW +: RCW]);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (v.alter) begin
            req_c[k*CW +: CW] = ~exp_core_c;
            req_fog[k]        = ~exp_fog;
        end
        n = 0; first_en = -1; busy = 0; rst_bad = 0; op_bad = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (core_en === 1'b1 && first_en < 0) first_en = n;
            if (core_en === 1'b1) busy++;
            if (core_reset !== ~core_en) rst_bad++;
            if (core_en === 1'b1 && (core_c !== exp_core_c || core_fog !== exp_fog)) op_bad++;
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        a = exp_q.pop_front();
        if (!got) begin
            n_checks++;
            $display("FAIL job%0d rsp_valid: got none within 100 cycles, required one", idx);
            return;
        end
        chk($sformatf("job%0d core_en latency", idx), CW'(first_en), CW'(2));
        chk($sformatf("job%0d rsp latency", idx), CW'(n), CW'(v.hang ? 2 + TO : 2 + STUB_LAT));
        chk($sformatf("job%0d busy cycles", idx), CW'(busy), CW'(v.hang ? TO : STUB_LAT));
        chk($sformatf("job%0d core_reset vs core_en", idx), CW'(rst_bad), CW'(0));
        chk($sformatf("job%0d latched operands", idx), CW'(op_bad), CW'(0));
        chk($sformatf("job%0d rsp_id", idx), CW'(rsp_id), CW'(a.id));
        chk($sformatf("job%0d rsp_err", idx), CW'(rsp_err), CW'(a.err));
        chk($sformatf("job%0d rsp_c", idx), rsp_c, a.c);
        chk($sformatf("job%0d rsp_x", idx), CW'(rsp_x), CW'(a.x));
        chk($sformatf("job%0d rsp_r", idx), CW'(rsp_r), CW'(a.r));
        bad = 0;
        for (int h = 0; h <= v.hold; h++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== a.id || rsp_err !== a.err || rsp_c !== a.c ||
                rsp_x !== a.x || rsp_r !== a.r || req_ready !== 2'b00) bad++;
            if (h < v.hold) @(negedge clk);
        end
        chk($sformatf("job%0d response hold", idx), CW'(bad), CW'(0));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        $display("job%0d: vmask=%b id=%0d err=%0d rsp_lat=%0d hold=%0d", idx, v.vmask, rsp_id,
                 rsp_err, n, v.hold);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   bad;
        bit   got;
        vec_t rv;
        //        vmask  fog    c0     c1      id hang hold alter
        vecs[0]  = '{2'b01, 2'b00, 32'h1, 32'h22, 0, 1'b0, 0,  1'b0};
        vecs[1]  = '{2'b10, 2'b00, 32'h5, 32'h33, 1, 1'b0, 0,  1'b0};
        vecs[2]  = '{2'b11, 2'b10, 32'h7, 32'h44, 0, 1'b0, 0,  1'b0};
        vecs[3]  = '{2'b11, 2'b10, 32'h9, 32'h55, 1, 1'b0, 0,  1'b0};
        vecs[4]  = '{2'b11, 2'b01, 32'hb, 32'h66, 0, 1'b0, 10, 1'b0};
        vecs[5]  = '{2'b11, 2'b01, 32'hd, 32'h77, 1, 1'b0, 0,  1'b0};
        vecs[6]  = '{2'b01, 2'b00, 32'hf, 32'h88, 0, 1'b1, 2,  1'b0};
        vecs[7]  = '{2'b01, 2'b00, 32'h11, 32'h99, 0, 1'b0, 0, 1'b0};
        vecs[8]  = '{2'b01, 2'b01, 32'h13, 32'haa, 0, 1'b0, 0, 1'b1};
        vecs[9]  = '{2'b10, 2'b00, 32'h15, 32'hbb, 1, 1'b0, 0, 1'b1};
        vecs[10] = '{2'b11, 2'b11, 32'h17, 32'hcc, 0, 1'b0, 3, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", CW'(req_ready), CW'(0));
        chk("reset rsp_valid", CW'(rsp_valid), CW'(0));
        chk("reset rsp_err", CW'(rsp_err), CW'(0));
        chk("reset rsp_id", CW'(rsp_id), CW'(0));
        chk("reset rsp_c", rsp_c, CW'(0));
        chk("reset rsp_r", CW'(rsp_r), CW'(0));
        chk("reset core_en", CW'(core_en), CW'(0));
        chk("reset core_reset", CW'(core_reset), CW'(1));
        chk("reset core_c", core_c, CW'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int j = 0; j < 11; j++) run_job(vecs[j], j);

        // Abort a job from requester 0 in its third BUSY cycle
        req_valid = 2'b00;
        rv = '{2'b01, 2'b00, 32'h21, 32'h31, 0, 1'b0, 0, 1'b0};
        load_operands(rv);
        req_valid = 2'b01;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) got = 1'b1;
        end
        chk("abort grant", CW'(req_ready), CW'(2'b01));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        chk("abort in busy", CW'(core_en), CW'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("abort rsp_valid", CW'(rsp_valid), CW'(0));
        chk("abort core_reset", CW'(core_reset), CW'(1));
        chk("abort core_en", CW'(core_en), CW'(0));
        chk("abort req_ready", CW'(req_ready), CW'(0));
        reset = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || core_en !== 1'b0) bad++;
        end
        chk("abort no response", CW'(bad), CW'(0));
        $display("abort: reset in busy cycle 3, quiet cycles with activity=%0d", bad);
        @(posedge clk);
        #1;
        // Pointer was 1 before the reset; requester 0 must win again afterwards
        rv = '{2'b11, 2'b00, 32'h41, 32'h51, 0, 1'b0, 0, 1'b0};
        run_job(rv, 11);
        req_valid = 2'b00;

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
